// File: rtl/cut_job_sequencer.sv
// Job sequencer for the wire cutter: feed, settle, cut, retract per piece until quantity is met.
// Optional feed watchdog enabled by defining WIRECUT_FEED_TIMEOUT_EN.
module cut_job_sequencer #(
  parameter int unsigned STEPS_PER_UNIT   = 126,
  parameter int unsigned SETTLE_CYC       = 2500000,
  parameter int unsigned CUT_HOLD_CYC     = 10000000,
  parameter int unsigned RETRACT_CYC      = 5000000,
  parameter int unsigned FEED_TIMEOUT_CYC = 250000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] length,
  input  logic [7:0]  quantity,
  input  logic        feed_done,
  output logic        feed_req,
  output logic [31:0] feed_steps,
  output logic        cut_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  pieces_cut
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StFeedReq, StFeedWait, StSettle, StCut, StRetract, StDone
  } state_e;

  // Last count value of each delay; a zero delay still occupies one cycle.
  localparam logic [31:0] SettleLast  = (SETTLE_CYC == 0)   ? 32'd0 : SETTLE_CYC - 1;
  localparam logic [31:0] CutLast     = (CUT_HOLD_CYC == 0) ? 32'd0 : CUT_HOLD_CYC - 1;
  localparam logic [31:0] RetractLast = (RETRACT_CYC == 0)  ? 32'd0 : RETRACT_CYC - 1;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  qty_q, qty_d;
  logic [7:0]  pieces_q, pieces_d, pieces_inc;
  logic [31:0] steps_q, steps_d;
  logic        error_q, error_d;
  logic        feed_req_q, feed_req_d;
  logic        cut_en_q, cut_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout;

`ifdef WIRECUT_FEED_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = (FEED_TIMEOUT_CYC == 0) ? 32'd0 : FEED_TIMEOUT_CYC - 1;
  assign timeout = (state_q == StFeedWait) && !feed_done && (cnt_q >= TimeoutLast);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^FEED_TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  assign pieces_inc = pieces_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    len_d    = len_q;
    qty_d    = qty_q;
    pieces_d = pieces_q;
    steps_d  = steps_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (length == 16'd0 || quantity == 8'd0) begin
            error_d = 1'b1;
          end else begin
            len_d    = length;
            qty_d    = quantity;
            error_d  = 1'b0;
            pieces_d = 8'd0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        steps_d = 32'(len_q) * STEPS_PER_UNIT;
        state_d = StFeedReq;
      end
      StFeedReq:  state_d = StFeedWait;
      StFeedWait: if (feed_done) state_d = StSettle;
      StSettle:   if (cnt_q >= SettleLast) state_d = StCut;
      StCut:      if (cnt_q >= CutLast) state_d = StRetract;
      StRetract: begin
        if (cnt_q >= RetractLast) begin
          pieces_d = pieces_inc;
          state_d  = (pieces_inc == qty_q) ? StDone : StFeedReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort and feed timeout override every transition; piece count is frozen.
    if (state_q != StIdle && (abort || timeout)) begin
      state_d  = StIdle;
      error_d  = 1'b1;
      pieces_d = pieces_q;
    end

    if (state_d != state_q || state_q == StIdle) cnt_d = 32'd0;

    feed_req_d = (state_d == StFeedReq);
    cut_en_d   = (state_d == StCut);
    done_d     = (state_d == StDone);
    busy_d     = (state_d != StIdle) && (state_d != StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= 32'd0;
      len_q      <= 16'd0;
      qty_q      <= 8'd0;
      pieces_q   <= 8'd0;
      steps_q    <= 32'd0;
      error_q    <= 1'b0;
      feed_req_q <= 1'b0;
      cut_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      qty_q      <= qty_d;
      pieces_q   <= pieces_d;
      steps_q    <= steps_d;
      error_q    <= error_d;
      feed_req_q <= feed_req_d;
      cut_en_q   <= cut_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign feed_req   = feed_req_q;
  assign feed_steps = steps_q;
  assign cut_en     = cut_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign pieces_cut = pieces_q;

endmodule

// File: tb/tb_cut_job_sequencer.sv
// Directed self-checking bench for cut_job_sequencer with shortened delays.
module tb_cut_job_sequencer;

  localparam int unsigned SettleCyc  = 3;
  localparam int unsigned CutHoldCyc = 4;
  localparam int unsigned RetractCyc = 2;
  localparam int unsigned TimeoutCyc = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        feed_done = 1'b0;
  logic [15:0] length = 16'd0;
  logic [7:0]  quantity = 8'd0;
  logic        feed_req, cut_en, busy, done, error;
  logic [31:0] feed_steps;
  logic [7:0]  pieces_cut;

  int n_checks = 0;
  int n_errors = 0;

  // Cumulative activity counters; tests compare deltas against snapshots.
  int feed_req_cycles = 0;
  int done_cycles = 0;
  int cut_pulses = 0;
  int cut_bad = 0;
  int cut_run = 0;

  int fr0, dn0, cp0, cb0, lost;

  cut_job_sequencer #(
    .STEPS_PER_UNIT  (126),
    .SETTLE_CYC      (SettleCyc),
    .CUT_HOLD_CYC    (CutHoldCyc),
    .RETRACT_CYC     (RetractCyc),
    .FEED_TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .length    (length),
    .quantity  (quantity),
    .feed_done (feed_done),
    .feed_req  (feed_req),
    .feed_steps(feed_steps),
    .cut_en    (cut_en),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .pieces_cut(pieces_cut)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    feed_req_cycles <= feed_req_cycles + {31'b0, feed_req};
    done_cycles     <= done_cycles + {31'b0, done};
    if (cut_en) begin
      cut_run <= cut_run + 1;
    end else if (cut_run != 0) begin
      cut_pulses <= cut_pulses + 1;
      if (cut_run != CutHoldCyc) cut_bad <= cut_bad + 1;
      cut_run <= 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic snap();
    fr0 = feed_req_cycles;
    dn0 = done_cycles;
    cp0 = cut_pulses;
    cb0 = cut_bad;
  endtask

  task automatic start_job(input logic [15:0] len, input logic [7:0] qty);
    length   = len;
    quantity = qty;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_feed_req(input string tag);
    int n = 0;
    while (!feed_req && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, feed_req}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_cut(input string tag);
    int n = 0;
    while (!cut_en && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, {31'b0, cut_en}, 32'd1);
  endtask

  // Called with feed_req visible; returns feed_done 5 cycles later.
  // With stray set, pulses start in FEED_WAIT and an extra feed_done in SETTLE.
  task automatic serve_feed(input bit stray);
    tick();
    if (stray) begin
      length   = 16'd9;
      quantity = 8'd1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      ticks(2);
    end else begin
      ticks(3);
    end
    feed_done = 1'b1;
    tick();
    feed_done = 1'b0;
    if (stray) begin
      feed_done = 1'b1;
      tick();
      feed_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    ticks(2);
    check_eq("rst_feed_req", {31'b0, feed_req}, 32'd0);
    check_eq("rst_feed_steps", feed_steps, 32'd0);
    check_eq("rst_cut_en", {31'b0, cut_en}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_error", {31'b0, error}, 32'd0);
    check_eq("rst_pieces", {24'b0, pieces_cut}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Normal job: length 10, quantity 2
    snap();
    start_job(16'd10, 8'd2);
    check_eq("t1_busy_after_start", {31'b0, busy}, 32'd1);
    check_eq("t1_no_req_in_load", {31'b0, feed_req}, 32'd0);
    tick();
    check_eq("t1_feed_req1", {31'b0, feed_req}, 32'd1);
    check_eq("t1_feed_steps", feed_steps, 32'd1260);
    check_eq("t1_pieces0", {24'b0, pieces_cut}, 32'd0);
    serve_feed(1'b0);
    wait_feed_req("t1_feed_req2");
    check_eq("t1_pieces1", {24'b0, pieces_cut}, 32'd1);
    serve_feed(1'b0);
    wait_done("t1_done");
    check_eq("t1_pieces2", {24'b0, pieces_cut}, 32'd2);
    check_eq("t1_busy_at_done", {31'b0, busy}, 32'd0);
    tick();
    check_eq("t1_done_one_cycle", {31'b0, done}, 32'd0);
    check_eq("t1_busy_after", {31'b0, busy}, 32'd0);
    check_eq("t1_error", {31'b0, error}, 32'd0);
    ticks(2);
    check_eq("t1_feed_req_count", 32'(feed_req_cycles - fr0), 32'd2);
    check_eq("t1_cut_pulses", 32'(cut_pulses - cp0), 32'd2);
    check_eq("t1_cut_bad_len", 32'(cut_bad - cb0), 32'd0);
    check_eq("t1_done_count", 32'(done_cycles - dn0), 32'd1);

    // Zero length rejected
    snap();
    start_job(16'd0, 8'd5);
    check_eq("t2_error", {31'b0, error}, 32'd1);
    check_eq("t2_busy", {31'b0, busy}, 32'd0);
    ticks(3);
    check_eq("t2_busy_stays", {31'b0, busy}, 32'd0);
    check_eq("t2_no_feed_req", 32'(feed_req_cycles - fr0), 32'd0);

    // Abort during the second CUT
    snap();
    start_job(16'd3, 8'd3);
    check_eq("t4_error_cleared", {31'b0, error}, 32'd0);
    check_eq("t4_busy", {31'b0, busy}, 32'd1);
    tick();
    check_eq("t4_feed_steps", feed_steps, 32'd378);
    serve_feed(1'b0);
    wait_feed_req("t4_feed_req2");
    serve_feed(1'b0);
    wait_cut("t4_cut2");
    check_eq("t4_pieces_in_cut", {24'b0, pieces_cut}, 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_cut_en_off", {31'b0, cut_en}, 32'd0);
    check_eq("t4_busy_off", {31'b0, busy}, 32'd0);
    check_eq("t4_error", {31'b0, error}, 32'd1);
    check_eq("t4_pieces_hold", {24'b0, pieces_cut}, 32'd1);
    ticks(3);
    check_eq("t4_no_done", 32'(done_cycles - dn0), 32'd0);
    check_eq("t4_stay_idle", {31'b0, busy}, 32'd0);
    check_eq("t4_pieces_hold2", {24'b0, pieces_cut}, 32'd1);

    // Restart with stray start and feed_done during the job
    snap();
    start_job(16'd3, 8'd3);
    check_eq("t5_error_cleared", {31'b0, error}, 32'd0);
    check_eq("t5_pieces_reset", {24'b0, pieces_cut}, 32'd0);
    check_eq("t5_busy", {31'b0, busy}, 32'd1);
    for (int p = 0; p < 3; p++) begin
      wait_feed_req("t5_feed_req");
      check_eq("t5_pieces_at_req", {24'b0, pieces_cut}, 32'(p));
      serve_feed(1'b1);
    end
    wait_done("t5_done");
    check_eq("t5_pieces_final", {24'b0, pieces_cut}, 32'd3);
    tick();
    check_eq("t5_feed_steps_kept", feed_steps, 32'd378);
    check_eq("t5_busy_after", {31'b0, busy}, 32'd0);
    check_eq("t5_error", {31'b0, error}, 32'd0);
    ticks(2);
    check_eq("t5_feed_req_count", 32'(feed_req_cycles - fr0), 32'd3);
    check_eq("t5_cut_pulses", 32'(cut_pulses - cp0), 32'd3);
    check_eq("t5_cut_bad_len", 32'(cut_bad - cb0), 32'd0);
    check_eq("t5_done_count", 32'(done_cycles - dn0), 32'd1);

    // Zero quantity rejected
    snap();
    start_job(16'd7, 8'd0);
    check_eq("t3_error", {31'b0, error}, 32'd1);
    check_eq("t3_busy", {31'b0, busy}, 32'd0);
    ticks(2);
    check_eq("t3_no_feed_req", 32'(feed_req_cycles - fr0), 32'd0);

    // feed_done never returns
    snap();
    start_job(16'd1, 8'd1);
    wait_feed_req("t6_feed_req");
    tick();
`ifdef WIRECUT_FEED_TIMEOUT_EN
    ticks(TimeoutCyc - 1);
    check_eq("t6_busy_before_timeout", {31'b0, busy}, 32'd1);
    tick();
    check_eq("t6_busy_timeout", {31'b0, busy}, 32'd0);
    check_eq("t6_error_timeout", {31'b0, error}, 32'd1);
`else
    lost = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!busy) lost++;
    end
    check_eq("t6_busy_lost_cycles", 32'(lost), 32'd0);
    check_eq("t6_error_none", {31'b0, error}, 32'd0);
    check_eq("t6_single_feed_req", 32'(feed_req_cycles - fr0), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t6_abort_busy", {31'b0, busy}, 32'd0);
    check_eq("t6_abort_error", {31'b0, error}, 32'd1);
`endif

    // Asynchronous reset during the second CUT
    start_job(16'd2, 8'd2);
    wait_feed_req("t7_feed_req1");
    serve_feed(1'b0);
    wait_feed_req("t7_feed_req2");
    check_eq("t7_pieces1", {24'b0, pieces_cut}, 32'd1);
    serve_feed(1'b0);
    wait_cut("t7_cut");
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_cut_en", {31'b0, cut_en}, 32'd0);
    check_eq("t7_rst_busy", {31'b0, busy}, 32'd0);
    check_eq("t7_rst_pieces", {24'b0, pieces_cut}, 32'd0);
    check_eq("t7_rst_feed_steps", feed_steps, 32'd0);
    check_eq("t7_rst_error", {31'b0, error}, 32'd0);
    ticks(2);
    reset_n = 1'b1;
    snap();
    ticks(3);
    check_eq("t7_idle_busy", {31'b0, busy}, 32'd0);
    check_eq("t7_idle_cut_en", {31'b0, cut_en}, 32'd0);
    check_eq("t7_idle_no_feed_req", 32'(feed_req_cycles - fr0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cut_job_sequencer.md
Name: cut_job_sequencer

Overview:
- Job-level controller for the wire cutter: takes the keypad length and quantity plus a start command.
- Sequences feed move, settle, blade cut and blade retract for each piece until the quantity is reached.
- Drives the stepper step generator through a request/done handshake and drives the cutter actuator enable.
- Sits between the keypad/UI logic and the step-pulse generator and cutter driver.

Parameters:
- STEPS_PER_UNIT, 126, stepper steps per length unit.
- SETTLE_CYC, 2500000, clk cycles to wait after feed_done before cutting (50 ms at 50 MHz).
- CUT_HOLD_CYC, 10000000, clk cycles cut_en is held high (200 ms).
- RETRACT_CYC, 5000000, clk cycles after cut_en drops before the next feed (100 ms).
- FEED_TIMEOUT_CYC, 250000000, maximum clk cycles in FEED_WAIT (5 s); used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle job start pulse.
- abort  input  1  level; any cycle high aborts the job.
- length  input  16  piece length in units.
- quantity  input  8  pieces to cut.
- feed_done  input  1  one-cycle pulse from step generator: move complete.
- feed_req  output  1  one-cycle pulse: start a feed move of feed_steps.
- feed_steps  output  32  step count for the move; stable for the whole job.
- cut_en  output  1  cutter actuator enable.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse: job completed normally.
- error  output  1  sticky; set on bad parameters, abort or timeout; cleared by next accepted start.
- pieces_cut  output  8  pieces completed in the current/last job.

Behaviour:
- All outputs registered. Reset values: feed_req=0, feed_steps=0, cut_en=0, busy=0, done=0, error=0, pieces_cut=0; state=IDLE.
- States: IDLE, LOAD, FEED_REQ, FEED_WAIT, SETTLE, CUT, RETRACT, DONE.
- IDLE, start=1:
  - If length==0 or quantity==0: error<=1, stay IDLE.
  - Otherwise: latch length/quantity, clear error and pieces_cut, busy<=1, go to LOAD. busy is visible the cycle after start.
- IDLE, start=0: no action; start seen in any other state is ignored.
- LOAD: feed_steps <= length*STEPS_PER_UNIT as an unsigned 32-bit product (no overflow for 16-bit length with the default); go to FEED_REQ.
- FEED_REQ: feed_req=1 for exactly one cycle; go to FEED_WAIT.
- FEED_WAIT:
  - feed_done is sampled only in this state.
  - On feed_done, go to SETTLE.
  - feed_done in any other state is ignored.
- SETTLE: wait SETTLE_CYC cycles, then go to CUT.
- CUT: cut_en=1 for exactly CUT_HOLD_CYC cycles, then go to RETRACT.
- RETRACT:
  - cut_en=0; wait RETRACT_CYC cycles.
  - On exit, pieces_cut increments by 1.
  - If the new value equals the latched quantity, go to DONE; otherwise go to FEED_REQ.
- DONE: done=1 for one cycle and busy<=0 in the same cycle; go to IDLE.
- A delay count of 0 behaves as 1 cycle.
- Abort (abort=1 in any non-IDLE state; priority over every other transition):
  - Next cycle: cut_en=0, feed_req=0, busy=0, error=1, state=IDLE.
  - pieces_cut holds its value; no done pulse.
  - abort in IDLE has no effect.
- Async reset mid-job: all outputs go immediately to their reset values.
- Simultaneous abort and feed_done: abort wins.
- Simultaneous start and abort in IDLE: start is processed normally.

Optional Feature:
- Macro WIRECUT_FEED_TIMEOUT_EN.
- Defined: a counter runs in FEED_WAIT. If feed_done has not arrived after FEED_TIMEOUT_CYC cycles, the block behaves exactly as an abort (error=1, busy=0, IDLE). The counter clears on entry to FEED_WAIT.
- Not defined: FEED_WAIT waits indefinitely and FEED_TIMEOUT_CYC is unused.

Test Plan:
- Overrides for all tests: SETTLE_CYC=3, CUT_HOLD_CYC=4, RETRACT_CYC=2.
- length=10, quantity=2, start; bench returns feed_done 5 cycles after each feed_req.
  - Expect feed_steps=1260, two feed_req pulses, two cut_en pulses of 4 cycles each.
  - Expect pieces_cut 0->1->2, a single done pulse, busy=0 afterwards, error=0.
- length=0, quantity=5, start -> error=1 next cycle, busy stays 0, no feed_req.
- Repeat with quantity=0 -> same result.
- Job length=3, quantity=3; assert abort during the second CUT.
  - Expect cut_en=0 and busy=0 the next cycle, error=1, pieces_cut=1, no done pulse.
  - Then a valid start -> error clears and pieces_cut resets to 0.
- During FEED_WAIT, pulse start and a second stray feed_done in SETTLE.
  - Expect start ignored; only one cut per feed; pieces_cut still reaches quantity exactly.
- Build with WIRECUT_FEED_TIMEOUT_EN and FEED_TIMEOUT_CYC=20; never return feed_done.
  - Expect error=1 and busy=0 exactly 20 cycles after entering FEED_WAIT.
  - Without the macro, the block stays in FEED_WAIT with busy=1 for 1000 cycles.
- Assert reset_n low mid-CUT -> cut_en, busy, pieces_cut go to 0 asynchronously; after release, IDLE.
